// File: rtl/mem_stage_lsu_pkg.sv
// ============================================================================
// Module      : mem_stage_lsu_pkg
// Description : Shared opcodes, funct3/size codes, exception causes and FSM
//               states for the load/store memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_lsu_pkg;

  localparam logic [6:0] L_OP = 7'b0000011;
  localparam logic [6:0] S_OP = 7'b0100011;
  localparam logic [6:0] I_OP = 7'b0010011;

  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_D  = 3'b011;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;
  localparam logic [2:0] c_F3_WU = 3'b110;

  localparam logic [1:0] c_SZ_B = 2'b00;
  localparam logic [1:0] c_SZ_H = 2'b01;
  localparam logic [1:0] c_SZ_W = 2'b10;

  localparam logic [3:0] c_CAUSE_LD_MISAL = 4'd4;
  localparam logic [3:0] c_CAUSE_LD_FAULT = 4'd5;
  localparam logic [3:0] c_CAUSE_ST_MISAL = 4'd6;
  localparam logic [3:0] c_CAUSE_ST_FAULT = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // Doubles and 32-bit-unsigned loads do not exist on XLEN=32 and report
  // as misaligned so the pipeline never issues them to the bus.
  function automatic logic f_misaligned(input logic [2:0] funct3,
                                        input logic [2:0] addr_lo,
                                        input int         xlen);
    logic v_mis;
    case (funct3[1:0])
      2'b00:   v_mis = 1'b0;
      2'b01:   v_mis = addr_lo[0];
      2'b10:   v_mis = |addr_lo[1:0];
      default: v_mis = (xlen == 32) || funct3[2] || (|addr_lo);
    endcase
    if ((xlen == 32) && (funct3 == c_F3_WU)) v_mis = 1'b1;
    return v_mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Store byte-enable / lane shifter and load extract / extend.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                  i_st_size,
  input  logic [$clog2(XLEN/8)-1:0]   i_st_off,
  input  logic [XLEN-1:0]             i_rs2,
  output logic [XLEN/8-1:0]           o_be,
  output logic [XLEN-1:0]             o_wdata,
  input  logic [2:0]                  i_ld_funct3,
  input  logic [$clog2(XLEN/8)-1:0]   i_ld_off,
  input  logic [XLEN-1:0]             i_rdata,
  output logic [XLEN-1:0]             o_ld_data
);

  localparam int NB = XLEN / 8;

  logic [NB-1:0]   w_mask;
  logic [6:0]      w_fill;
  logic [XLEN-1:0] w_shift;
  logic [XLEN-1:0] w_left;
  logic [XLEN-1:0] w_sext;

  always_comb begin
    case (i_st_size)
      c_SZ_B:  w_mask = NB'(1);
      c_SZ_H:  w_mask = NB'(3);
      c_SZ_W:  w_mask = NB'(15);
      default: w_mask = '1;
    endcase
  end

  assign o_be    = w_mask << i_st_off;
  assign o_wdata = i_rs2 << {i_st_off, 3'b000};

  // Push the field to the top, then shift back arithmetically or logically.
  always_comb begin
    case (i_ld_funct3[1:0])
      c_SZ_B:  w_fill = 7'(XLEN - 8);
      c_SZ_H:  w_fill = 7'(XLEN - 16);
      c_SZ_W:  w_fill = 7'(XLEN - 32);
      default: w_fill = 7'd0;
    endcase
  end

  assign w_shift   = i_rdata >> {i_ld_off, 3'b000};
  assign w_left    = w_shift << w_fill;
  assign w_sext    = $signed(w_left) >>> w_fill;
  assign o_ld_data = i_ld_funct3[2] ? (w_left >> w_fill) : w_sext;

endmodule

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// ============================================================================
// Module      : mem_stage_lsu
// Description : Registered request/ack load/store memory stage with alignment
//               and bus-fault exceptions. Optional ack watchdog: LSU_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int XADDR          = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_rs2,
  input  logic [XLEN-1:0]   i_alu_result,
  input  logic [XADDR-1:0]  i_rd_addr,
  input  logic              i_rd_write,
  input  logic [XLEN-1:0]   i_pc,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_be,
  input  logic              i_mem_ack,
  input  logic              i_mem_err,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic              o_wb_valid,
  output logic [XLEN-1:0]   o_wb_pc,
  output logic [XADDR-1:0]  o_wb_rd_addr,
  output logic              o_wb_rd_write,
  output logic [XLEN-1:0]   o_wb_rd_data,
  output logic              o_exc_valid,
  output logic [3:0]        o_exc_cause,
  output logic [XLEN-1:0]   o_exc_tval
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  lsu_state_e      r_state;
  logic            r_killed;
  logic [2:0]      r_funct3;
  logic            r_mem_req, r_mem_we;
  logic [XLEN-1:0] r_mem_addr, r_mem_wdata;
  logic [NB-1:0]   r_mem_be;
  logic            r_wb_valid, r_wb_rd_write;
  logic [XLEN-1:0] r_wb_pc, r_wb_rd_data;
  logic [XADDR-1:0] r_wb_rd_addr;
  logic            r_exc_valid;
  logic [3:0]      r_exc_cause;
  logic [XLEN-1:0] r_exc_tval;

  logic            w_is_load, w_is_store, w_is_mem, w_accept, w_misal;
  logic            w_kill, w_timeout;
  logic [NB-1:0]   w_be;
  logic [XLEN-1:0] w_wdata, w_ld_data;

  assign w_is_load  = (i_opcode == L_OP);
  assign w_is_store = (i_opcode == S_OP);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_accept   = (r_state != ST_BUSY) & i_valid & ~i_flush;
  assign w_misal    = f_misaligned(i_funct3, i_alu_result[2:0], XLEN);
  assign w_kill     = r_killed | i_flush;
  assign o_stall    = (r_state == ST_BUSY) | (w_accept & w_is_mem & ~w_misal);

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_st_size   (i_funct3[1:0]),
    .i_st_off    (i_alu_result[OFFW-1:0]),
    .i_rs2       (i_rs2),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .i_ld_funct3 (r_funct3),
    .i_ld_off    (r_exc_tval[OFFW-1:0]),
    .i_rdata     (i_mem_rdata),
    .o_ld_data   (w_ld_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wd_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_wd_cnt <= '0;
    else if (r_state == ST_BUSY) r_wd_cnt <= r_wd_cnt + 1'b1;
    else                         r_wd_cnt <= '0;
  end

  assign w_timeout = (r_wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // r_exc_tval doubles as the saved effective address for the whole access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_killed      <= 1'b0;
      r_funct3      <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_be      <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_pc       <= '0;
      r_wb_rd_addr  <= '0;
      r_wb_rd_write <= 1'b0;
      r_wb_rd_data  <= '0;
      r_exc_valid   <= 1'b0;
      r_exc_cause   <= '0;
      r_exc_tval    <= '0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_exc_valid <= 1'b0;
      case (r_state)
        ST_BUSY: begin
          if (i_flush) r_killed <= 1'b1;
          if (i_mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_DONE;
            if (!w_kill) begin
              if (i_mem_err) begin
                r_exc_valid <= 1'b1;
                r_exc_cause <= r_mem_we ? c_CAUSE_ST_FAULT : c_CAUSE_LD_FAULT;
              end else begin
                r_wb_valid   <= 1'b1;
                r_wb_rd_data <= r_mem_we ? '0 : w_ld_data;
              end
            end
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_DONE;
            if (!w_kill) begin
              r_exc_valid <= 1'b1;
              r_exc_cause <= r_mem_we ? c_CAUSE_ST_FAULT : c_CAUSE_LD_FAULT;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          if (w_accept) begin
            r_wb_pc      <= i_pc;
            r_wb_rd_addr <= i_rd_addr;
            if (!w_is_mem) begin
              r_wb_valid    <= 1'b1;
              r_wb_rd_write <= i_rd_write;
              r_wb_rd_data  <= i_alu_result;
            end else begin
              r_wb_rd_write <= i_rd_write & w_is_load;
              r_exc_tval    <= i_alu_result;
              if (w_misal) begin
                r_exc_valid <= 1'b1;
                r_exc_cause <= w_is_store ? c_CAUSE_ST_MISAL : c_CAUSE_LD_MISAL;
                r_state     <= ST_DONE;
              end else begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_is_store;
                r_mem_addr  <= {i_alu_result[XLEN-1:OFFW], {OFFW{1'b0}}};
                r_mem_wdata <= w_wdata;
                r_mem_be    <= w_is_store ? w_be : '0;
                r_funct3    <= i_funct3;
                r_killed    <= 1'b0;
                r_state     <= ST_BUSY;
              end
            end
          end
        end
      endcase
    end
  end

  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_mem_be      = r_mem_be;
  assign o_wb_valid    = r_wb_valid;
  assign o_wb_pc       = r_wb_pc;
  assign o_wb_rd_addr  = r_wb_rd_addr;
  assign o_wb_rd_write = r_wb_rd_write;
  assign o_wb_rd_data  = r_wb_rd_data;
  assign o_exc_valid   = r_exc_valid;
  assign o_exc_cause   = r_exc_cause;
  assign o_exc_tval    = r_exc_tval;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench for mem_stage_lsu (directed + random ops).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam int XLEN  = 32;
  localparam int XADDR = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_valid, i_rd_write, i_flush, i_mem_ack, i_mem_err;
  logic [6:0]        i_opcode;
  logic [2:0]        i_funct3;
  logic [XLEN-1:0]   i_rs2, i_alu_result, i_pc, i_mem_rdata;
  logic [XADDR-1:0]  i_rd_addr;
  logic              o_stall, o_mem_req, o_mem_we, o_wb_valid, o_wb_rd_write, o_exc_valid;
  logic [XLEN-1:0]   o_mem_addr, o_mem_wdata, o_wb_pc, o_wb_rd_data, o_exc_tval;
  logic [XLEN/8-1:0] o_mem_be;
  logic [XADDR-1:0]  o_wb_rd_addr;
  logic [3:0]        o_exc_cause;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] ld_f3 [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(XLEN), .XADDR(XADDR), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_opcode(i_opcode),
    .i_funct3(i_funct3), .i_rs2(i_rs2), .i_alu_result(i_alu_result),
    .i_rd_addr(i_rd_addr), .i_rd_write(i_rd_write), .i_pc(i_pc), .i_flush(i_flush),
    .o_stall(o_stall), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_ack(i_mem_ack), .i_mem_err(i_mem_err), .i_mem_rdata(i_mem_rdata),
    .o_wb_valid(o_wb_valid), .o_wb_pc(o_wb_pc), .o_wb_rd_addr(o_wb_rd_addr),
    .o_wb_rd_write(o_wb_rd_write), .o_wb_rd_data(o_wb_rd_data),
    .o_exc_valid(o_exc_valid), .o_exc_cause(o_exc_cause), .o_exc_tval(o_exc_tval)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_cycle();
    step();
    check("idle_wb", o_wb_valid, 0);
    check("idle_exc", o_exc_valid, 0);
    check("idle_req", o_mem_req, 0);
  endtask

  // Reference: sizes, lanes and extension computed from the ISA rules directly.
  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [31:0] rdata,
                       input int dly, input bit err, input bit flush);
    bit          is_ld, is_st, mis;
    int          sz, off, d;
    logic [31:0] pc, v, m, exp_wdata;
    logic [4:0]  rd;
    bit          rdw;
    logic [3:0]  exp_be;
    is_ld = (op == L_OP);
    is_st = (op == S_OP);
    pc    = $urandom;
    rd    = 5'($urandom);
    rdw   = 1'($urandom);
    sz    = 1 << f3[1:0];
    off   = addr % 4;
    mis   = (is_ld || is_st) && ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (addr % sz != 0));
    d     = (flush && dly == 0) ? 1 : dly;

    i_valid = 1; i_opcode = op; i_funct3 = f3; i_alu_result = addr; i_rs2 = rs2;
    i_pc = pc; i_rd_addr = rd; i_rd_write = rdw; i_flush = 0;
    #1 check("stall_accept", o_stall, 64'((is_ld || is_st) && !mis));
    step();
    i_valid = 0;

    if (!(is_ld || is_st)) begin
      check("alu_wb_valid", o_wb_valid, 1);
      check("alu_rd_data", o_wb_rd_data, addr);
      check("alu_rd_write", o_wb_rd_write, rdw);
      check("alu_pc", o_wb_pc, pc);
      check("alu_rd_addr", o_wb_rd_addr, rd);
      check("alu_stall", o_stall, 0);
      return;
    end
    if (mis) begin
      check("mis_exc", o_exc_valid, 1);
      check("mis_cause", o_exc_cause, is_st ? 6 : 4);
      check("mis_tval", o_exc_tval, addr);
      check("mis_req", o_mem_req, 0);
      check("mis_wb", o_wb_valid, 0);
      return;
    end

    exp_be    = 4'(((1 << sz) - 1) << off);
    exp_wdata = rs2 << (8 * off);
    check("req", o_mem_req, 1);
    check("we", o_mem_we, is_st);
    check("addr", o_mem_addr, addr & 32'hFFFF_FFFC);
    if (is_st) begin
      check("be", o_mem_be, exp_be);
      check("wdata", o_mem_wdata, exp_wdata);
    end
    for (int c = 0; c < d; c++) begin
      check("busy_stall", o_stall, 1);
      if (flush && c == 0) i_flush = 1;
      step();
      i_flush = 0;
      check("req_hold", o_mem_req, 1);
      check("addr_hold", o_mem_addr, addr & 32'hFFFF_FFFC);
    end
    i_mem_ack = 1; i_mem_err = err; i_mem_rdata = rdata;
    step();
    i_mem_ack = 0; i_mem_err = 0; i_mem_rdata = $urandom;

    check("done_stall", o_stall, 0);
    check("done_req", o_mem_req, 0);
    check("done_wb", o_wb_valid, !flush && !err);
    check("done_exc", o_exc_valid, !flush && err);
    if (!flush && !err) begin
      check("wb_rd_write", o_wb_rd_write, is_ld && rdw);
      check("wb_pc", o_wb_pc, pc);
      if (is_ld) begin
        v = rdata >> (8 * off);
        if (sz < 4) begin
          m = (32'h1 << (8 * sz)) - 1;
          v = v & m;
          if (!f3[2] && v[8*sz-1]) v = v | ~m;
        end
        check("ld_data", o_wb_rd_data, v);
      end
    end
    if (!flush && err) begin
      check("fault_cause", o_exc_cause, is_st ? 7 : 5);
      check("fault_tval", o_exc_tval, addr);
    end
  endtask

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    int          sel;
    rst_n = 0; i_valid = 0; i_opcode = '0; i_funct3 = '0; i_rs2 = '0; i_alu_result = '0;
    i_pc = '0; i_rd_addr = '0; i_rd_write = 0; i_flush = 0; i_mem_ack = 0; i_mem_err = 0;
    i_mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", o_stall, 0);
    check("rst_req", o_mem_req, 0);
    check("rst_wb", o_wb_valid, 0);
    check("rst_exc", o_exc_valid, 0);
    check("rst_addr", o_mem_addr, 0);
    check("rst_rd_data", o_wb_rd_data, 0);
    rst_n = 1;
    step();

    do_op(L_OP, 3'b010, 32'h100, 0, 32'hDEADBEEF, 2, 0, 0);
    check("lw_exact", o_wb_rd_data, 32'hDEADBEEF);
    quiet_cycle();
    do_op(L_OP, 3'b000, 32'h103, 0, 32'h80123456, 0, 0, 0);
    check("lb_exact", o_wb_rd_data, 32'hFFFFFF80);
    do_op(L_OP, 3'b100, 32'h103, 0, 32'h80123456, 1, 0, 0);
    check("lbu_exact", o_wb_rd_data, 32'h00000080);
    do_op(S_OP, 3'b001, 32'h102, 32'h1234, 0, 0, 0, 0);
    do_op(L_OP, 3'b010, 32'h101, 0, 0, 0, 0, 0);
    do_op(S_OP, 3'b010, 32'h101, 0, 0, 0, 0, 0);
    do_op(L_OP, 3'b011, 32'h100, 0, 0, 0, 0, 0);
    do_op(L_OP, 3'b010, 32'h200, 0, 32'h12345678, 2, 0, 1);
    quiet_cycle();
    do_op(L_OP, 3'b010, 32'h300, 0, 32'h0, 1, 1, 0);
    do_op(I_OP, 3'b000, 32'hCAFE0001, 0, 0, 0, 0, 0);
    quiet_cycle();

    // Flushed input in IDLE is dropped entirely.
    i_valid = 1; i_flush = 1; i_opcode = L_OP; i_funct3 = 3'b010; i_alu_result = 32'h400;
    step();
    i_valid = 0; i_flush = 0;
    check("drop_req", o_mem_req, 0);
    check("drop_wb", o_wb_valid, 0);
    check("drop_exc", o_exc_valid, 0);

    // Stray ack while idle must be ignored.
    i_mem_ack = 1; i_mem_rdata = 32'h55AA55AA;
    step();
    i_mem_ack = 0;
    check("stray_wb", o_wb_valid, 0);
    check("stray_exc", o_exc_valid, 0);

    // Asynchronous reset while a request is outstanding.
    i_valid = 1; i_opcode = S_OP; i_funct3 = 3'b010; i_alu_result = 32'h500;
    step();
    i_valid = 0;
    check("pre_rst_req", o_mem_req, 1);
    rst_n = 0;
    #1;
    check("mid_rst_req", o_mem_req, 0);
    check("mid_rst_stall", o_stall, 0);
    step();
    rst_n = 1;
    quiet_cycle();

    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 2);
      op  = (sel == 0) ? ((($urandom & 1) != 0) ? I_OP : 7'b0110011) : (sel == 1) ? L_OP : S_OP;
      f3  = (sel == 1) ? ld_f3[$urandom_range(0, 6)] : 3'($urandom_range(0, 3));
      do_op(op, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      if (($urandom & 1) != 0) quiet_cycle();
    end
    quiet_cycle();

`ifdef LSU_TIMEOUT_EN
    i_valid = 1; i_opcode = S_OP; i_funct3 = 3'b010; i_alu_result = 32'h600;
    step();
    i_valid = 0;
    for (int c = 0; c < 4; c++) begin
      check("wd_req_hold", o_mem_req, 1);
      if (c < 3) step();
    end
    step();
    check("wd_req_drop", o_mem_req, 0);
    check("wd_exc", o_exc_valid, 1);
    check("wd_cause", o_exc_cause, 7);
    check("wd_tval", o_exc_tval, 32'h600);
    quiet_cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
